if_fetch_buffer: RTL

Parametrised instruction-fetch front end for the LA32 pipeline. It replaces the single IF stage register with a PC generator, a pipelined request/response link to the instruction cache, and a DEPTH-entry in-order fetch queue. It sits between the instruction cache and the ID stage, decoupling cache latency from decode stalls, and discards wrong-path fetches when EX signals a branch redirect.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/if_fetch_buffer.sv | 111 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared LA32 fetch-path widths, reset PC and fetch entry type
package cpu_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_INST_W = 32;
  localparam logic [31:0] CPU_RESET_PC = 32'h1c00_0000;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] pc;
    logic [CPU_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parametrised synchronous FIFO with flush; pop-first when full
module sync_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_INST_W,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign pop_ok  = pop_i && !empty_o;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/if_fetch_buffer.sv
// rtl/if_fetch_buffer.sv - LA32 fetch front end: PC gen, credited cache link, fetch queue
// Optional IFB_BYPASS_EN: responses bypass an empty queue straight to ID.
module if_fetch_buffer
  import cpu_pkg::*;
#(
  parameter int               ADDR_W   = CPU_ADDR_W,
  parameter int               INST_W   = CPU_INST_W,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [INST_W-1:0] resp_inst,
  output logic              resp_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = ADDR_W + INST_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]     shadow_count, fq_count;
  logic [CW-1:0]     outstanding;
  logic              shadow_full, shadow_empty, fq_full, fq_empty;
  logic [ADDR_W-1:0] shadow_pc;
  logic [EW-1:0]     fq_rdata;
  logic              req_fire, resp_take, fq_push, fq_pop;

  // Requests in flight are the live PCs in the shadow FIFO plus wrong-path ones awaiting discard.
  assign outstanding = shadow_count + drop_cnt_q;
  assign resp_ready  = 1'b1;
  assign req_addr    = fetch_pc_q;
  assign req_valid   = !reset && !redirect_valid && !shadow_full &&
                       (({1'b0, outstanding} + {1'b0, fq_count}) < (CW+1)'(DEPTH));
  assign req_fire    = req_valid && req_ready;
  assign resp_take   = resp_valid && (drop_cnt_q == '0) && !redirect_valid && !shadow_empty;
  assign fq_pop      = out_ready && !fq_empty;

`ifdef IFB_BYPASS_EN
  logic bypass;
  assign bypass    = resp_take && fq_empty;
  assign out_valid = !fq_empty || bypass;
  assign out_pc    = bypass ? shadow_pc : fq_rdata[EW-1:INST_W];
  assign out_inst  = bypass ? resp_inst : fq_rdata[INST_W-1:0];
  assign fq_push   = resp_take && (!fq_full || fq_pop) && !(bypass && out_ready);
`else
  assign out_valid = !fq_empty;
  assign out_pc    = fq_rdata[EW-1:INST_W];
  assign out_inst  = fq_rdata[INST_W-1:0];
  assign fq_push   = resp_take && (!fq_full || fq_pop);
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      drop_cnt_d = outstanding - CW'(resp_valid && (outstanding != '0));
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_shadow (
    .clk     (clk),
    .rst     (reset),
    .push_i  (req_fire),
    .pop_i   (resp_take),
    .flush_i (redirect_valid),
    .wdata_i (fetch_pc_q),
    .rdata_o (shadow_pc),
    .full_o  (shadow_full),
    .empty_o (shadow_empty),
    .count_o (shadow_count)
  );

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fetch_q (
    .clk     (clk),
    .rst     (reset),
    .push_i  (fq_push),
    .pop_i   (fq_pop),
    .flush_i (redirect_valid),
    .wdata_i ({shadow_pc, resp_inst}),
    .rdata_o (fq_rdata),
    .full_o  (fq_full),
    .empty_o (fq_empty),
    .count_o (fq_count)
  );

endmodule
